bin_to_bcd_serial: RTL

Sequential binary-to-BCD converter using serial shift-and-add-3 (double dabble). It produces the packed BCD digits and the per-digit blank mask that feed the team's seven-segment display path. Game logic (scores, shot counts, ships remaining) hands it a binary value through a start/done handshake. The result is held stable until the next conversion completes.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bin_to_bcd_serial.sv | 119 +++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  function automatic logic digit_is_valid(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: values of five or more get +3 before the shift.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= ADD3_THRESHOLD) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter with a per-digit blank mask.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 never blanked).
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int BIN_W      = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [NUM_DIGITS-1:0]   blank,
  output state_t                  dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE); the edge that sees it captures bin.
  // Starts during SHIFT/DONE are dropped. done pulses one cycle exactly when bcd/blank update.

  localparam int SCR_W = 4 * NUM_DIGITS;
  localparam int SR_W  = SCR_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  generate
    if (!((64'd10 ** NUM_DIGITS) > ((64'd1 << BIN_W) - 64'd1))) begin : g_width_check
      $error("bin_to_bcd_serial: NUM_DIGITS too small to hold 2**BIN_W-1");
    end
  endgenerate

  state_t           state_q;
  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_next;
  logic [SCR_W-1:0] scr_adj;
  logic [SCR_W-1:0] scr_next;
  logic [NUM_DIGITS-1:0] blank_next;
  logic [CNT_W-1:0] cnt_q;
  logic             last_shift;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_in  (sr_q[BIN_W + 4*gi +: 4]),
        .digit_out (scr_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign sr_adj     = {scr_adj, sr_q[BIN_W-1:0]};
  assign sr_next    = sr_adj << 1;
  assign scr_next   = sr_next[SR_W-1 -: SCR_W];
  assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    // Walk down from the top digit; a digit blanks only while everything above it is zero.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above && (scr_next[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end
`else
  assign blank_next = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      blank   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sr_q    <= {{SCR_W{1'b0}}, bin};
            cnt_q   <= '0;
            state_q <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          sr_q  <= sr_next;
          cnt_q <= cnt_q + CNT_W'(1);
          // The final shift result goes straight to the outputs on the same edge.
          if (last_shift) begin
            state_q <= DONE;
            bcd     <= scr_next;
            blank   <= blank_next;
            done    <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule
